// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: MIPS opcode/funct values, scheduler state encoding
// and the default EX occupancy of a multi-cycle multiply.
package pipeline_pkg;

   localparam logic [5:0] OP_RTYPE  = 6'h00;
   localparam logic [5:0] OP_BEQ    = 6'h04;
   localparam logic [5:0] OP_MUL    = 6'h1c;
   localparam logic [5:0] FUNCT_MUL = 6'h02;
   localparam logic [5:0] OP_LW     = 6'h23;
   localparam logic [5:0] OP_SW     = 6'h2b;

   localparam int MUL_CYCLES_DEFAULT = 4;

   typedef enum logic {
      RUN = 1'b0,
      MUL = 1'b1
   } schedState_t;

endpackage

// File: rtl/mul_timer.sv
// Loadable down-counter tracking the remaining EX cycles of a multiply.
// Latency: load takes effect on the next edge; done is combinational (count == 0).
// No backpressure: counts down one per cycle until it reaches zero, then holds.
module mul_timer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] loadVal,
   output logic             done
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (load) begin
         count <= loadVal;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign done = (count == '0);

endmodule

// File: rtl/hazard_scheduler.sv
// Pipeline hazard scheduler: load-use stalls, branch/jump flushes, multi-cycle mul hold.
// Latency: all control outputs are combinational (zero cycles); stall_cycles updates per edge.
// Backpressure: stall_if/stall_id hold upstream stages; optional MUL hold under MUL_MULTICYCLE_EN.
module hazard_scheduler
   import pipeline_pkg::*;
#(
   parameter int MUL_CYCLES = MUL_CYCLES_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  id_opcode,
   input  logic [5:0]  id_funct,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic [1:0]  id_pcsrc,
   input  logic        ex_mem_read,
   input  logic [4:0]  ex_rt_dst,
   input  logic        ex_branch_taken,
   output logic        stall_if,
   output logic        stall_id,
   output logic        flush_ifid,
   output logic        flush_idex,
   output logic        bubble_exmem,
   output logic        mul_busy,
   output logic [15:0] stall_cycles
);

   logic usesRt;
   logic loadUse;
   logic runIdle;
   logic busy;

   always_comb begin
      usesRt  = id_opcode inside {OP_RTYPE, OP_BEQ, OP_SW, OP_MUL};
      loadUse = ex_mem_read && (ex_rt_dst != 5'd0) &&
                ((ex_rt_dst == id_rs) || (usesRt && (ex_rt_dst == id_rt)));
      runIdle = !ex_branch_taken && !loadUse && (id_pcsrc == 2'b00);
   end

`ifdef MUL_MULTICYCLE_EN
   schedState_t state;
   schedState_t stateNext;
   logic        isMul;
   logic        mulLoad;
   logic        mulDone;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= RUN;
      end else begin
         state <= stateNext;
      end
   end

   // A MUL whose counter has run out behaves as RUN, so a following mul may re-enter.
   always_comb begin
      stateNext = state;
      busy      = 1'b0;
      mulLoad   = 1'b0;
      isMul     = (id_opcode == OP_MUL) && (id_funct == FUNCT_MUL);
      case (state)
         MUL: busy = !mulDone;
         default: busy = 1'b0;
      endcase
      if (!busy && isMul && (MUL_CYCLES > 1) && runIdle) begin
         mulLoad   = 1'b1;
         stateNext = MUL;
      end else if (!busy) begin
         stateNext = RUN;
      end
   end

   mul_timer #(
      .WIDTH (4)
   ) u_mulTimer (
      .clk     (clk),
      .reset   (reset),
      .load    (mulLoad),
      .loadVal (4'(MUL_CYCLES - 1)),
      .done    (mulDone)
   );
`else
   logic [9:0] unusedMulFields;

   assign unusedMulFields = {id_funct, 4'(MUL_CYCLES)};
   assign busy            = 1'b0;
`endif

   // Reset gates every control output so nothing leaks while the pipeline is held in reset.
   always_comb begin
      stall_if     = 1'b0;
      stall_id     = 1'b0;
      flush_ifid   = 1'b0;
      flush_idex   = 1'b0;
      bubble_exmem = 1'b0;
      mul_busy     = 1'b0;
      if (reset) begin
         if (busy) begin
            stall_if     = 1'b1;
            stall_id     = 1'b1;
            bubble_exmem = 1'b1;
            mul_busy     = 1'b1;
         end else if (ex_branch_taken) begin
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
         end else if (loadUse) begin
            stall_if   = 1'b1;
            flush_idex = 1'b1;
         end else if (id_pcsrc != 2'b00) begin
            flush_ifid = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cycles <= 16'd0;
      end else if (stall_if && (stall_cycles != 16'hFFFF)) begin
         stall_cycles <= stall_cycles + 16'd1;
      end
   end

endmodule

// File: tb/tb_hazard_scheduler.sv
// Self-checking bench for hazard_scheduler: directed scenarios plus randomized
// stimulus against a behavioural model of the scheduling rules.
module tb_hazard_scheduler;

   localparam int MC = 4;
`ifdef MUL_MULTICYCLE_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  id_opcode;
   logic [5:0]  id_funct;
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic [1:0]  id_pcsrc;
   logic        ex_mem_read;
   logic [4:0]  ex_rt_dst;
   logic        ex_branch_taken;
   logic        stall_if;
   logic        stall_id;
   logic        flush_ifid;
   logic        flush_idex;
   logic        bubble_exmem;
   logic        mul_busy;
   logic [15:0] stall_cycles;

   wire [5:0] ctrlObs = {stall_if, stall_id, flush_ifid, flush_idex, bubble_exmem, mul_busy};

   int checks   = 0;
   int failures = 0;
   int mBusy    = 0;   // remaining busy cycles of the mul in EX
   int mStalls  = 0;   // saturating stall count

   always #5 clk = ~clk;

   hazard_scheduler #(.MUL_CYCLES(MC)) dut (
      .clk             (clk),
      .reset           (reset),
      .id_opcode       (id_opcode),
      .id_funct        (id_funct),
      .id_rs           (id_rs),
      .id_rt           (id_rt),
      .id_pcsrc        (id_pcsrc),
      .ex_mem_read     (ex_mem_read),
      .ex_rt_dst       (ex_rt_dst),
      .ex_branch_taken (ex_branch_taken),
      .stall_if        (stall_if),
      .stall_id        (stall_id),
      .flush_ifid      (flush_ifid),
      .flush_idex      (flush_idex),
      .bubble_exmem    (bubble_exmem),
      .mul_busy        (mul_busy),
      .stall_cycles    (stall_cycles)
   );

   function automatic bit idIsMul();
      return (id_opcode == 6'h1c) && (id_funct == 6'h02);
   endfunction

   // Expected {stall_if, stall_id, flush_ifid, flush_idex, bubble_exmem, mul_busy}.
   function automatic logic [5:0] modelCtrl();
      bit usesRt;
      bit lu;
      usesRt = (id_opcode == 6'h00) || (id_opcode == 6'h04) ||
               (id_opcode == 6'h2b) || (id_opcode == 6'h1c);
      lu = ex_mem_read && (ex_rt_dst != 0) &&
           ((ex_rt_dst == id_rs) || (usesRt && (ex_rt_dst == id_rt)));
      if (!reset)              return 6'b000000;
      if (mBusy > 0)           return 6'b110011;
      if (ex_branch_taken)     return 6'b001100;
      if (lu)                  return 6'b100100;
      if (id_pcsrc != 2'b00)   return 6'b001000;
      return 6'b000000;
   endfunction

   task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [1:0] pc, input logic memRd,
                        input logic [4:0] dst, input logic br);
      id_opcode = op; id_funct = fn; id_rs = rs; id_rt = rt; id_pcsrc = pc;
      ex_mem_read = memRd; ex_rt_dst = dst; ex_branch_taken = br;
   endtask

   // Advance one clock edge and update the model; leaves time at posedge + 1.
   task automatic tick();
      logic [5:0] e;
      bit         mulNow;
      e      = modelCtrl();
      mulNow = idIsMul();
      @(posedge clk);
      if (!reset) begin
         mBusy = 0; mStalls = 0;
      end else begin
         if (e[5] && mStalls < 65535) mStalls++;
         if (mBusy > 0) mBusy--;
         else if (MUL_EN && MC > 1 && mulNow && e == 6'b000000) mBusy = MC - 1;
      end
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      drive(6'h00, 6'h20, 5'd8, 5'd9, 2'd1, 1'b1, 5'd8, 1'b1);
      #2;
      checks++;
      if (ctrlObs !== 6'b000000) begin
         failures++; $display("FAIL reset_ctrl got=%b want=%b", ctrlObs, 6'b000000);
      end
      checks++;
      if (stall_cycles !== 16'd0) begin
         failures++; $display("FAIL reset_count got=%0d want=0", stall_cycles);
      end
      @(posedge clk); #1;
      reset = 1'b1;
      drive(6'h00, 6'h20, 5'd1, 5'd2, 2'd0, 1'b0, 5'd0, 1'b0);
      tick();
   endtask

   task automatic test_load_use();
      int base;
      base = mStalls;
      drive(6'h00, 6'h20, 5'd8, 5'd3, 2'd0, 1'b1, 5'd8, 1'b0);
      @(negedge clk);
      checks++;
      if (ctrlObs !== 6'b100100) begin
         failures++; $display("FAIL load_use_ctrl got=%b want=%b", ctrlObs, 6'b100100);
      end
      tick();
      drive(6'h00, 6'h20, 5'd8, 5'd3, 2'd0, 1'b0, 5'd0, 1'b0);
      @(negedge clk);
      checks++;
      if (ctrlObs !== 6'b000000) begin
         failures++; $display("FAIL load_use_release got=%b want=%b", ctrlObs, 6'b000000);
      end
      checks++;
      if (stall_cycles !== 16'(base + 1)) begin
         failures++; $display("FAIL load_use_count got=%0d want=%0d", stall_cycles, base + 1);
      end
      // lw uses only rs: an rt match on a load in ID is not a hazard
      drive(6'h23, 6'h00, 5'd4, 5'd8, 2'd0, 1'b1, 5'd8, 1'b0);
      @(negedge clk);
      checks++;
      if (ctrlObs !== 6'b000000) begin
         failures++; $display("FAIL load_rt_only got=%b want=%b", ctrlObs, 6'b000000);
      end
      tick();
   endtask

   task automatic test_zero_reg();
      drive(6'h00, 6'h20, 5'd0, 5'd0, 2'd0, 1'b1, 5'd0, 1'b0);
      @(negedge clk);
      checks++;
      if (ctrlObs !== 6'b000000) begin
         failures++; $display("FAIL zero_reg got=%b want=%b", ctrlObs, 6'b000000);
      end
      tick();
   endtask

   task automatic test_branch_priority();
      drive(6'h00, 6'h20, 5'd8, 5'd3, 2'd1, 1'b1, 5'd8, 1'b1);
      @(negedge clk);
      checks++;
      if (ctrlObs !== 6'b001100) begin
         failures++; $display("FAIL branch_over_load got=%b want=%b", ctrlObs, 6'b001100);
      end
      tick();
      drive(6'h02, 6'h00, 5'd0, 5'd0, 2'd2, 1'b0, 5'd0, 1'b0);
      @(negedge clk);
      checks++;
      if (ctrlObs !== 6'b001000) begin
         failures++; $display("FAIL jump_flush got=%b want=%b", ctrlObs, 6'b001000);
      end
      tick();
   endtask

   task automatic test_mul();
      int         base;
      logic [5:0] want;
      base = mStalls;
      drive(6'h1c, 6'h02, 5'd1, 5'd2, 2'd0, 1'b0, 5'd0, 1'b0);
      @(negedge clk);
      checks++;
      if (ctrlObs !== 6'b000000) begin
         failures++; $display("FAIL mul_entry got=%b want=%b", ctrlObs, 6'b000000);
      end
      tick();
      for (int i = 0; i < MC - 1; i++) begin
         drive(6'h00, 6'h20, 5'd1, 5'd2, (i == 1) ? 2'd1 : 2'd0, 1'b0, 5'd0, 1'b0);
         want = MUL_EN ? 6'b110011 : ((i == 1) ? 6'b001000 : 6'b000000);
         @(negedge clk);
         checks++;
         if (ctrlObs !== want) begin
            failures++; $display("FAIL mul_busy_%0d got=%b want=%b", i, ctrlObs, want);
         end
         tick();
      end
      drive(6'h00, 6'h20, 5'd1, 5'd2, 2'd0, 1'b0, 5'd0, 1'b0);
      @(negedge clk);
      checks++;
      if (ctrlObs !== 6'b000000) begin
         failures++; $display("FAIL mul_done got=%b want=%b", ctrlObs, 6'b000000);
      end
      checks++;
      if (stall_cycles !== 16'(base + (MUL_EN ? MC - 1 : 0))) begin
         failures++; $display("FAIL mul_count got=%0d want=%0d", stall_cycles,
                              base + (MUL_EN ? MC - 1 : 0));
      end
      tick();
   endtask

   task automatic test_reset_mid_mul();
      drive(6'h1c, 6'h02, 5'd1, 5'd2, 2'd0, 1'b0, 5'd0, 1'b0);
      tick();
      drive(6'h00, 6'h20, 5'd1, 5'd2, 2'd0, 1'b0, 5'd0, 1'b0);
      tick();
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if (ctrlObs !== 6'b000000) begin
         failures++; $display("FAIL mid_mul_reset_ctrl got=%b want=%b", ctrlObs, 6'b000000);
      end
      checks++;
      if (stall_cycles !== 16'd0) begin
         failures++; $display("FAIL mid_mul_reset_count got=%0d want=0", stall_cycles);
      end
      mBusy = 0; mStalls = 0;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      drive(6'h00, 6'h20, 5'd5, 5'd2, 2'd0, 1'b1, 5'd5, 1'b0);
      @(negedge clk);
      checks++;
      if (ctrlObs !== 6'b100100) begin
         failures++; $display("FAIL after_reset_run got=%b want=%b", ctrlObs, 6'b100100);
      end
      tick();
   endtask

   task automatic test_random();
      logic [5:0] e;
      logic [4:0] dst;
      for (int n = 0; n < 400; n++) begin
         dst = 5'($urandom_range(0, 3));
         case ($urandom_range(0, 5))
            0: id_opcode = 6'h00;
            1: id_opcode = 6'h04;
            2: id_opcode = 6'h2b;
            3: id_opcode = 6'h23;
            4: id_opcode = 6'h02;
            default: id_opcode = 6'h1c;
         endcase
         id_funct        = ($urandom_range(0, 1) == 0) ? 6'h02 : 6'h20;
         id_rs           = 5'($urandom_range(0, 3));
         id_rt           = 5'($urandom_range(0, 3));
         id_pcsrc        = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
         ex_mem_read     = ($urandom_range(0, 2) == 0);
         ex_rt_dst       = dst;
         ex_branch_taken = ($urandom_range(0, 9) == 0);
         @(negedge clk);
         e = modelCtrl();
         checks++;
         if (ctrlObs !== e) begin
            failures++; $display("FAIL rand_ctrl_%0d got=%b want=%b", n, ctrlObs, e);
         end
         checks++;
         if (stall_cycles !== 16'(mStalls)) begin
            failures++; $display("FAIL rand_count_%0d got=%0d want=%0d", n, stall_cycles, mStalls);
         end
         tick();
      end
   endtask

   task automatic test_saturation();
      drive(6'h00, 6'h20, 5'd7, 5'd3, 2'd0, 1'b1, 5'd7, 1'b0);
      for (int n = 0; n < 65540; n++) tick();
      @(negedge clk);
      checks++;
      if (stall_cycles !== 16'hFFFF || mStalls != 65535) begin
         failures++; $display("FAIL sat_count got=%h want=%h", stall_cycles, 16'hFFFF);
      end
      checks++;
      if (stall_if !== 1'b1) begin
         failures++; $display("FAIL sat_stall got=%b want=1", stall_if);
      end
      tick();
      @(negedge clk);
      checks++;
      if (stall_cycles !== 16'hFFFF) begin
         failures++; $display("FAIL sat_hold got=%h want=%h", stall_cycles, 16'hFFFF);
      end
      tick();
   endtask

   initial begin
      reset = 1'b0;
      drive(6'h00, 6'h00, 5'd0, 5'd0, 2'd0, 1'b0, 5'd0, 1'b0);
      test_reset();
      test_load_use();
      test_zero_reg();
      test_branch_priority();
      test_mul();
      test_reset_mid_mul();
      test_random();
      test_saturation();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hazard_scheduler.md
HAZARD_SCHEDULER -- requirements
Module: hazard_scheduler

Interface
REQ-001 Parameter: MUL_CYCLES, default 4, EX-stage occupancy of mul (OpCode 6'h1c, Funct 6'h02) in cycles; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low; clears all state immediately when low.
REQ-004 id_opcode  input  6  OpCode of the instruction in ID.
REQ-005 id_funct  input  6  Funct of the instruction in ID.
REQ-006 id_rs  input  5  rs field of the instruction in ID.
REQ-007 id_rt  input  5  rt field of the instruction in ID.
REQ-008 id_pcsrc  input  2  PCSrc decoded in ID; nonzero means j/jal/jr/jalr.
REQ-009 ex_mem_read  input  1  instruction in EX is a load.
REQ-010 ex_rt_dst  input  5  destination register of the instruction in EX.
REQ-011 ex_branch_taken  input  1  beq in EX resolved taken.
REQ-012 stall_if  output  1  hold PC and IF/ID.
REQ-013 stall_id  output  1  hold ID/EX.
REQ-014 flush_ifid  output  1  zero IF/ID on next edge.
REQ-015 flush_idex  output  1  insert bubble into ID/EX on next edge.
REQ-016 bubble_exmem  output  1  insert bubble into EX/MEM on next edge.
REQ-017 mul_busy  output  1  mul occupying EX with cycles remaining.
REQ-018 stall_cycles  output  16  saturating count of cycles with stall_if high.

Function
- REQ-019 uses_rt is true for id_opcode 6'h00, 6'h04, 6'h2b, 6'h1c.
- REQ-020 load_use = ex_mem_read AND ex_rt_dst != 0 AND (ex_rt_dst == id_rs OR (uses_rt AND ex_rt_dst == id_rt)).
- REQ-021 FSM states: RUN, MUL.
- REQ-022 RUN to MUL occurs when ID holds mul, MUL_CYCLES > 1, and no stall or flush is issued that cycle.
- REQ-023 On the RUN-to-MUL transition, the down-counter loads MUL_CYCLES-1.
- REQ-024 In MUL with counter != 0:
  - mul_busy, stall_if, stall_id and bubble_exmem are 1; all flushes are 0.
  - The counter decrements each cycle.
- REQ-025 In MUL with counter == 0, the FSM returns to RUN and outputs follow the RUN rules that same cycle. Total mul EX occupancy is MUL_CYCLES cycles.
- REQ-026 Priority in RUN, highest first:
  - ex_branch_taken: flush_ifid=1, flush_idex=1.
  - load_use: stall_if=1, flush_idex=1.
  - id_pcsrc != 0: flush_ifid=1.
  - Otherwise all outputs 0.
- REQ-027 A taken branch concurrent with mul in ID suppresses the MUL entry, because the mul is flushed.
- REQ-028 load_use concurrent with mul in ID suppresses the MUL entry; the mul re-evaluates the next cycle.
- REQ-029 All control outputs are combinational from state and inputs; zero-cycle latency.
- REQ-030 stall_cycles increments on each edge where stall_if is 1 and holds at 16'hFFFF.

Reset
- REQ-031 While reset is low: state = RUN, counter = 0, stall_cycles = 0, and all control outputs are 0 regardless of the other inputs.
- REQ-032 Reset asserted mid-MUL aborts the occupancy; the first cycle after release is evaluated in RUN.

Configuration
- REQ-033 Macro MUL_MULTICYCLE_EN defined: mul behaviour is as given in REQ-021..REQ-028.
- REQ-034 Macro MUL_MULTICYCLE_EN undefined:
  - The MUL state and counter are absent and mul_busy is tied to 0.
  - mul is treated as single-cycle, and MUL_CYCLES is ignored.

Structure
- REQ-035 Shared package pipeline_pkg holds:
  - the opcode/funct constants (6'h00, 6'h04, 6'h1c, 6'h02, 6'h23, 6'h2b);
  - the RUN/MUL state encoding;
  - the MUL_CYCLES default.
- REQ-036 One sub-module, mul_timer, holds the loadable down-counter; it outputs done and is instantiated only under MUL_MULTICYCLE_EN.

Verification
- REQ-037 Load-use: ex_mem_read=1, ex_rt_dst=8, ID add with id_rs=8 -> stall_if=1 and flush_idex=1 for exactly 1 cycle; stall_cycles 0->1.
- REQ-038 Zero-register load-use: ex_rt_dst=0 with id_rs=0 -> no stall.
- REQ-039 Branch over load-use: ex_branch_taken=1 together with a load_use match -> flush_ifid=1, flush_idex=1, stall_if=0.
- REQ-040 mul with MUL_CYCLES=4 -> mul_busy=1 and stall_if=1 for 3 cycles, then RUN; stall_cycles +3.
- REQ-041 Reset mid-mul: reset low during the 2nd busy cycle -> all outputs 0 immediately; after release state=RUN and stall_cycles=0.
- REQ-042 Saturation and macro:
  - Preload the stall count near max via forced stalls -> stall_cycles holds 16'hFFFF.
  - Build without MUL_MULTICYCLE_EN -> a mul produces no stall.
